// File: rtl/seg_scan_pkg.sv
// Shared constants and FSM state type for the multiplexed seven-segment scan driver.
package seg_scan_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_BRIGHT = 2'd1;
    localparam logic [1:0] ADDR_DIV    = 2'd2;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam int         PHASES    = 16;

    typedef enum logic [1:0] {
        OFF,
        DRIVE,
        GUARD
    } scan_state_e;

endpackage

// File: rtl/seg_scan_driver_if.sv
// Write-only Avalon-MM configuration bus of the scan driver.
interface seg_scan_driver_if;

    logic [1:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic        chipselect;

    modport master (
        output address,
        output write,
        output writedata,
        output chipselect
    );

    modport slave (
        input address,
        input write,
        input writedata,
        input chipselect
    );

endinterface

// File: rtl/seg_scan_prescaler.sv
// Refresh prescaler: counts down from the divider and emits a 1-cycle tick at zero.
module seg_scan_prescaler #(
    parameter int               DIV_W       = 16,
    parameter logic [DIV_W-1:0] DEFAULT_DIV = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             run,
    input  logic [DIV_W-1:0] divider,
    output logic             tick
);

    logic [DIV_W-1:0] count;

    assign tick = run && (count == '0);

    // The divider is only sampled on reload, so a new value never cuts a period short.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= DEFAULT_DIV;
        end else if (!run || tick) begin
            count <= divider;
        end else begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Two-digit time-multiplexed seven-segment driver with programmable refresh and brightness.
module seg_scan_driver
    import seg_scan_pkg::*;
#(
    parameter int               DIV_W          = 16,
    parameter logic [DIV_W-1:0] DEFAULT_DIV    = DIV_W'(2499),
    parameter logic [3:0]       DEFAULT_BRIGHT = 4'd15
) (
    input  logic              clk,
    input  logic              reset_n,
    seg_scan_driver_if.slave  bus,
    input  logic [6:0]        segs0,
    input  logic [6:0]        segs1,
    output logic [6:0]        seg_out,
    output logic [1:0]        dig_en_n
);

    logic             enable;
    logic [3:0]       brightness;
    logic [DIV_W-1:0] divider;

    logic wr_en;
    logic ctrl_wr;
    logic stop;

    assign wr_en   = bus.chipselect && bus.write;
    assign ctrl_wr = wr_en && (bus.address == ADDR_CTRL);
    // A disable write stops the scan at its own edge; an enable write is seen one edge later.
    assign stop    = !enable || (ctrl_wr && !bus.writedata[0]);

    logic unused_wdata;
    assign unused_wdata = &{1'b0, bus.writedata[31:DIV_W]};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            enable     <= 1'b1;
            brightness <= DEFAULT_BRIGHT;
            divider    <= DEFAULT_DIV;
        end else if (wr_en) begin
            case (bus.address)
                ADDR_CTRL:   enable     <= bus.writedata[0];
                ADDR_BRIGHT: brightness <= bus.writedata[3:0];
                ADDR_DIV:    divider    <= bus.writedata[DIV_W-1:0];
                default:     ;
            endcase
        end
    end

    scan_state_e state, state_nxt;
    logic [3:0]  phase;
    logic        digit;
    logic [6:0]  pattern;
    logic        run;
    logic        tick;

    assign run = (state != OFF) && !stop;

    seg_scan_prescaler #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .run     (run),
        .divider (divider),
        .tick    (tick)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= OFF;
        end else begin
            state <= state_nxt;
        end
    end

    // Phase is held at 0 while OFF, so leaving OFF picks GUARD exactly when brightness is 0.
    always_comb begin
        state_nxt = state;
        if (stop) begin
            state_nxt = OFF;
        end else if (phase < brightness) begin
            state_nxt = DRIVE;
        end else begin
            state_nxt = GUARD;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || !run) begin
            phase <= '0;
            digit <= 1'b0;
        end else if (tick) begin
            phase <= phase + 1'b1;
            if (phase == 4'(PHASES - 1)) begin
                digit <= ~digit;
            end
        end
    end

    // Pattern is captured once per slot, as the slot's phase 0 begins.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pattern <= SEG_BLANK;
        end else if (state == OFF && !stop) begin
            pattern <= segs0;
        end else if (run && tick && phase == 4'(PHASES - 1)) begin
            pattern <= digit ? segs0 : segs1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            seg_out  <= SEG_BLANK;
            dig_en_n <= 2'b11;
        end else if (state == DRIVE) begin
            seg_out  <= pattern;
            dig_en_n <= digit ? 2'b01 : 2'b10;
        end else begin
            seg_out  <= SEG_BLANK;
            dig_en_n <= 2'b11;
        end
    end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed display driver placed directly downstream of the seven-segment decoder. It takes the decoder's two active-low segment patterns (segs0, segs1) and drives one shared segment bus plus two active-low digit enables. The multiplexed digit board needs only 7+2 pins, and the block adds programmable refresh rate and brightness. It is configured by an Avalon-MM write-only slave using the same bus handshake as the decoder.

## Interface
- DIV_W, 16, width of refresh divider register
- DEFAULT_DIV, 16'd2499, reset value of divider; tick period = divider+1 clk cycles
- DEFAULT_BRIGHT, 4'd15, reset value of brightness
- clk  in  1  system clock; single clock domain
- reset_n  in  1  reset, synchronous, active-low
- address  in  2  register select: 0 = CTRL, 1 = BRIGHT, 2 = DIV, 3 = reserved (writes ignored)
- write  in  1  write strobe, qualified by chipselect
- writedata  in  32  write data
- chipselect  in  1  slave select
- segs0  in  7  digit 0 pattern, active-low, from decoder
- segs1  in  7  digit 1 pattern, active-low, from decoder
- seg_out  out  7  shared segment bus, active-low, registered
- dig_en_n  out  2  digit enables, active-low, one-hot-low or 2'b11, registered

## Operation
- Register write when chipselect && write at a rising edge:
  - CTRL[0] = enable.
  - BRIGHT[3:0] = brightness.
  - DIV[DIV_W-1:0] = divider.
  - Upper bits are ignored. There is no read path.
- Reset values: enable=1, brightness=DEFAULT_BRIGHT, divider=DEFAULT_DIV.
- Prescaler counts down from divider. At 0 it asserts tick for one cycle and reloads. A new divider value is used at the next reload, never mid-count.
- Phase counter (4 bit) advances on tick. Digit index toggles on the tick that wraps phase 15→0, so each slot is 16 ticks.
- FSM states:
  - OFF: enable=0. Counters held at 0, digit index 0, prescaler loaded with divider.
  - DRIVE: phase < brightness.
  - GUARD: phase ≥ brightness.
- Transitions:
  - Any state → OFF when enable=0.
  - OFF → DRIVE when enable=1 (or GUARD if brightness=0).
  - DRIVE ↔ GUARD is re-evaluated every cycle from phase and brightness.
- Outputs per state:
  - DRIVE: seg_out = latched pattern of current digit; dig_en_n = 2'b10 for digit 0, 2'b01 for digit 1.
  - GUARD and OFF: seg_out = 7'h7F, dig_en_n = 2'b11.
- Pattern latch: the current digit's segsN is sampled on entry to phase 0 of each slot and held for the whole slot. Mid-slot changes on segs0/segs1 are not visible until that digit's next slot.
- Brightness:
  - brightness=15 gives 15/16 duty. Phase 15 is always blanked and acts as an anti-ghosting gap between digits.
  - brightness=0 gives permanently blank output while counters keep running.

## Timing
- Reset (reset_n low at an edge): seg_out=7'h7F, dig_en_n=2'b11, phase=0, digit=0, prescaler=DEFAULT_DIV, registers at reset values.
- First edge with reset_n high: internal state is digit 0, phase 0, and the pattern latch loads segs0. Outputs reflect DRIVE of digit 0 one edge later (1-cycle output register latency), if DEFAULT_BRIGHT>0.
- Brightness write is effective on the next cycle's state evaluation; outputs change 2 edges after the write edge.
- Enable write 1→0: counters clear at the write edge, and outputs are blank at the following edge. Enable 0→1: restarts at digit 0 phase 0, with the same latency as reset release.
- Reset asserted mid-slot: outputs blank at that edge, regardless of state.
- Simultaneous tick and DIV write: the reload uses the old divider; the new value applies from the next reload.
- Digit switch always passes through ≥1 tick of GUARD, so both enables are never low together.

## Structure
- Package seg_scan_pkg holds:
  - register address constants ADDR_CTRL=0, ADDR_BRIGHT=1, ADDR_DIV=2;
  - SEG_BLANK=7'h7F;
  - PHASES=16;
  - the FSM state enum {OFF, DRIVE, GUARD}.
- One sub-module: seg_scan_prescaler. It holds the down-counter with deferred reload, takes the divider as input and produces a 1-cycle tick.

## Test plan
- Reset and DEFAULT_DIV=3, brightness 15, segs0=7'h40, segs1=7'h79 → dig_en_n=2'b10 with seg_out=7'h40 for 60 cycles, blank for 4, then 2'b01 with 7'h79 for 60, blank for 4, repeating every 128 cycles.
- Write BRIGHT=4 → each slot shows 16 cycles on, 48 cycles blank. Write BRIGHT=0 → output constantly 7'h7F/2'b11.
- Change segs0 mid-slot from 7'h40 to 7'h24 → seg_out stays 7'h40 until digit 0's next slot, then shows 7'h24.
- Write DIV=7 mid-count → current tick period finishes at 4 cycles, then ticks every 8 cycles, so the slot lengthens to 128 cycles.
- Write CTRL=0 during DRIVE → blank on the next edge. Write CTRL=1 → digit 0 shown 2 edges later from phase 0.
- Assert reset_n=0 mid-slot → outputs 7'h7F/2'b11 immediately. Check throughout that dig_en_n is never 2'b00.
